regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port (wr/wreg/wdata) between two write-back requesters in the multi-cycle CPU: requester 0 is the ALU result path, requester 1 is the load/memory path.
- Round-robin arbitration with a valid/ready handshake.
- One registered output stage drives the register-file write port.
- A 32-entry pending-write scoreboard tells the control FSM whether a source register still awaits write-back.

---
 rtl/regfile_wb_arbiter.sv | 119 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin write-back arbiter with pending-write scoreboard
// Optional macro WB_BYPASS_EN adds same-cycle forwarding of the write port to the source queries.
module regfile_wb_arbiter #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [AW-1:0] req0_reg,
  input  logic [DW-1:0] req0_data,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [AW-1:0] req1_reg,
  input  logic [DW-1:0] req1_data,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_reg,
  input  logic [AW-1:0] q1_reg,
  input  logic [AW-1:0] q2_reg,
  output logic          q1_busy,
  output logic          q2_busy,
  output logic          wr,
  output logic [AW-1:0] wreg,
  output logic [DW-1:0] wdata
`ifdef WB_BYPASS_EN
  ,
  output logic          q1_fwd_hit,
  output logic [DW-1:0] q1_fwd_data,
  output logic          q2_fwd_hit,
  output logic [DW-1:0] q2_fwd_data
`endif
);

  logic            r_ptr;
  logic            r_wr;
  logic [AW-1:0]   r_wreg;
  logic [DW-1:0]   r_wdata;
  logic [NREG-1:0] r_busy;

  logic            w_xfer0;
  logic            w_xfer1;
  logic            w_xfer;
  logic [AW-1:0]   w_sel_reg;
  logic [DW-1:0]   w_sel_data;
  logic [NREG-1:0] w_busy_nxt;
  logic            w_q1_hit;
  logic            w_q2_hit;

  // Ready depends only on the other requester and the pointer, so at most one transfer per cycle.
  assign req0_ready = !(req1_valid && r_ptr);
  assign req1_ready = !(req0_valid && !r_ptr);

  assign w_xfer0    = req0_valid && req0_ready;
  assign w_xfer1    = req1_valid && req1_ready;
  assign w_xfer     = w_xfer0 || w_xfer1;
  assign w_sel_reg  = w_xfer1 ? req1_reg  : req0_reg;
  assign w_sel_data = w_xfer1 ? req1_data : req0_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= 1'b0;
      r_wr    <= 1'b0;
      r_wreg  <= '0;
      r_wdata <= '0;
    end else if (w_xfer) begin
      r_ptr <= w_xfer0;
      // Writes to register 0 are absorbed: handshake completes but the port stays idle.
      r_wr  <= (w_sel_reg != '0);
      if (w_sel_reg != '0) begin
        r_wreg  <= w_sel_reg;
        r_wdata <= w_sel_data;
      end
    end else begin
      r_wr <= 1'b0;
    end
  end

  // Clear applied before set so a newly issued instruction keeps ownership of its register.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_wr) begin
      w_busy_nxt[r_wreg] = 1'b0;
    end
    if (iss_valid && (iss_reg != '0)) begin
      w_busy_nxt[iss_reg] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

`ifdef WB_BYPASS_EN
  assign w_q1_hit    = r_wr && (r_wreg == q1_reg) && (q1_reg != '0);
  assign w_q2_hit    = r_wr && (r_wreg == q2_reg) && (q2_reg != '0);
  assign q1_fwd_hit  = w_q1_hit;
  assign q2_fwd_hit  = w_q2_hit;
  assign q1_fwd_data = r_wdata;
  assign q2_fwd_data = r_wdata;
`else
  assign w_q1_hit = 1'b0;
  assign w_q2_hit = 1'b0;
`endif

  assign q1_busy = r_busy[q1_reg] && !w_q1_hit;
  assign q2_busy = r_busy[q2_reg] && !w_q2_hit;

  assign wr    = r_wr;
  assign wreg  = r_wreg;
  assign wdata = r_wdata;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - randomized self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [AW-1:0] req0_reg, req1_reg;
  logic [DW-1:0] req0_data, req1_data;
  logic          iss_valid;
  logic [AW-1:0] iss_reg, q1_reg, q2_reg;
  logic          q1_busy, q2_busy;
  logic          wr;
  logic [AW-1:0] wreg;
  logic [DW-1:0] wdata;
`ifdef WB_BYPASS_EN
  logic          q1_fwd_hit, q2_fwd_hit;
  logic [DW-1:0] q1_fwd_data, q2_fwd_data;
`endif

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_reg(req0_reg), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_reg(req1_reg), .req1_data(req1_data),
    .iss_valid(iss_valid), .iss_reg(iss_reg), .q1_reg(q1_reg), .q2_reg(q2_reg),
    .q1_busy(q1_busy), .q2_busy(q2_busy), .wr(wr), .wreg(wreg), .wdata(wdata)
`ifdef WB_BYPASS_EN
    , .q1_fwd_hit(q1_fwd_hit), .q1_fwd_data(q1_fwd_data),
    .q2_fwd_hit(q2_fwd_hit), .q2_fwd_data(q2_fwd_data)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: who is favoured next, which registers await write-back, what the port shows.
  int            m_favour;
  bit            m_pending[NREG];
  bit            m_wr;
  int            m_wreg;
  logic [DW-1:0] m_wdata;
  int            last_win;

  function automatic bit exp_busy(input int q);
    bit hit;
    hit = m_wr && (m_wreg == q) && (q != 0);
`ifdef WB_BYPASS_EN
    return m_pending[q] && !hit;
`else
    return m_pending[q] && !(hit && 1'b0);
`endif
  endfunction

  task automatic cycle();
    int win;
    int r;
    logic [DW-1:0] d;
    #1;
    if (!rst) begin
      check("req0_ready", req0_ready, !(req1_valid && m_favour == 1));
      check("req1_ready", req1_ready, !(req0_valid && m_favour == 0));
      check("q1_busy", q1_busy, exp_busy(int'(q1_reg)));
      check("q2_busy", q2_busy, exp_busy(int'(q2_reg)));
`ifdef WB_BYPASS_EN
      check("q1_fwd_hit", q1_fwd_hit, m_wr && m_wreg == int'(q1_reg) && q1_reg != 0);
      check("q2_fwd_hit", q2_fwd_hit, m_wr && m_wreg == int'(q2_reg) && q2_reg != 0);
      if (q1_fwd_hit) check("q1_fwd_data", q1_fwd_data, m_wdata);
`endif
    end
    win = -1;
    if (!rst) begin
      if (req0_valid && req1_valid) win = m_favour;
      else if (req0_valid)          win = 0;
      else if (req1_valid)          win = 1;
    end
    r = (win == 1) ? int'(req1_reg) : int'(req0_reg);
    d = (win == 1) ? req1_data : req0_data;
    @(posedge clk);
    if (rst) begin
      m_favour = 0;
      foreach (m_pending[i]) m_pending[i] = 1'b0;
      m_wr = 1'b0; m_wreg = 0; m_wdata = '0;
    end else begin
      if (m_wr) m_pending[m_wreg] = 1'b0;
      if (iss_valid && iss_reg != 0) m_pending[iss_reg] = 1'b1;
      if (win >= 0) begin
        m_favour = 1 - win;
        m_wr = (r != 0);
        if (r != 0) begin m_wreg = r; m_wdata = d; end
      end else begin
        m_wr = 1'b0;
      end
    end
    last_win = win;
    #1;
    check("wr", wr, m_wr);
    check("wreg", wreg, m_wreg);
    check("wdata", wdata, m_wdata);
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; req0_reg = 0; req1_reg = 0; req0_data = 0; req1_data = 0;
    iss_valid = 0; iss_reg = 0; q1_reg = 0; q2_reg = 0;
    m_favour = 0; m_wr = 0; m_wreg = 0; m_wdata = '0; last_win = -1;
    foreach (m_pending[i]) m_pending[i] = 1'b0;
    @(posedge clk); #1;
    cycle();
    check("rst_wr", wr, 0);
    check("rst_wreg", wreg, 0);
    check("rst_wdata", wdata, 0);
    rst = 1'b0;

    q1_reg = 5;
    cycle();
    check("idle_q1_busy", q1_busy, 0);

    req0_valid = 1; req0_reg = 3; req0_data = 32'h11;
    cycle();
    check("single_wr", wr, 1);
    check("single_wreg", wreg, 3);
    check("single_wdata", wdata, 32'h11);
    req0_valid = 0;
    cycle();
    check("single_wr_drop", wr, 0);

    // Contention from a fresh pointer.
    rst = 1; cycle(); rst = 0;
    for (int rep = 0; rep < 2; rep++) begin
      req0_valid = 1; req0_reg = 1; req0_data = 32'hA;
      req1_valid = 1; req1_reg = 2; req1_data = 32'hB;
      for (int c = 0; c < 4; c++) begin
        cycle();
        if (c == 0) check("cont_first_wreg", wreg, 1);
        if (c == 1) check("cont_second_wreg", wreg, 2);
        if (last_win == 0) req0_valid = 0;
        if (last_win == 1) req1_valid = 0;
      end
    end

    iss_valid = 1; iss_reg = 7; q1_reg = 7;
    cycle();
    iss_valid = 0;
    check("sb_set", q1_busy, 1);
    req1_valid = 1; req1_reg = 7; req1_data = 32'h77;
    cycle();
    req1_valid = 0;
    #1;
`ifdef WB_BYPASS_EN
    check("sb_wr_cycle_bypass", q1_busy, 0);
    check("sb_fwd_hit", q1_fwd_hit, 1);
    check("sb_fwd_data", q1_fwd_data, 32'h77);
`else
    check("sb_wr_cycle", q1_busy, 1);
`endif
    cycle();
    check("sb_cleared", q1_busy, 0);

    iss_valid = 1; iss_reg = 9; q1_reg = 9;
    cycle();
    iss_valid = 0; req0_valid = 1; req0_reg = 9; req0_data = 32'h99;
    cycle();
    req0_valid = 0; iss_valid = 1; iss_reg = 9;
    cycle();
    iss_valid = 0;
    check("same_edge_keep", q1_busy, 1);

    req0_valid = 1; req0_reg = 0; req0_data = 32'h55;
    cycle();
    req0_valid = 0;
    check("r0_wr", wr, 0);
    iss_valid = 1; iss_reg = 0; q1_reg = 0;
    cycle();
    iss_valid = 0;
    check("r0_busy", q1_busy, 0);

    iss_valid = 1; iss_reg = 12; q1_reg = 12;
    cycle();
    iss_valid = 0;
    req1_valid = 1; req1_reg = 4; req1_data = 32'h44; rst = 1;
    cycle();
    rst = 0;
    check("rst_hold_wr", wr, 0);
    check("rst_sb_clear", q1_busy, 0);
    req0_valid = 1; req0_reg = 6; req0_data = 32'h66;
    cycle();
    check("rst_ptr_wreg", wreg, 6);
    req0_valid = 0; req1_valid = 0;
    cycle();

    for (int i = 0; i < 3000; i++) begin
      if (!req0_valid || last_win == 0) begin
        req0_valid = 1'($urandom_range(0, 1));
        req0_reg   = AW'($urandom_range(0, 15));
        req0_data  = $urandom;
      end
      if (!req1_valid || last_win == 1) begin
        req1_valid = 1'($urandom_range(0, 1));
        req1_reg   = AW'($urandom_range(0, 15));
        req1_data  = $urandom;
      end
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_reg   = AW'($urandom_range(0, 15));
      q1_reg    = AW'($urandom_range(0, 15));
      q2_reg    = AW'($urandom_range(0, 15));
      rst       = ($urandom_range(0, 249) == 0);
      cycle();
    end
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
